// File: rtl/axis_dac_player_pkg.sv
// Shared widths, FSM state type and stream-word field accessors for the DAC playback path.
package axis_dac_player_pkg;

  localparam int SAMPLE_W = 14;
  localparam int TS_W     = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Word layout matches the ADC capture stream: {sample, timestamp}.
  function automatic logic [SAMPLE_W-1:0] get_sample(input logic [63:0] word);
    return word[63 -: SAMPLE_W];
  endfunction

  function automatic logic [TS_W-1:0] get_ts(input logic [63:0] word);
    return word[TS_W-1:0];
  endfunction

endpackage

// File: rtl/axis_dac_player_fifo.sv
// First-word-fall-through synchronous FIFO; rdata always shows the head word while not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign level   = wr_q - rd_q;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axis_dac_player.sv
// AXI-Stream sink that buffers {sample, timestamp} words and drives each sample to the DAC
// when the local timebase reaches its stamp; stale samples are dropped and counted.
module axis_dac_player
  import axis_dac_player_pkg::*;
#(
  parameter int                     TIME_STEP  = 8,
  parameter int                     FIFO_DEPTH = 512,
  parameter logic [SAMPLE_W-1:0]    IDLE_CODE  = 14'h0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   packet_size,
  input  logic [63:0]                   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [7:0]                    s_axis_tkeep,
  output logic [SAMPLE_W-1:0]           dac_out,
  output logic                          playing,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   late_count,
  output logic                          underrun,
  output logic                          framing_err,
  output logic [1:0]                    dbg_state_o
);

  // Stream handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
  // s_axis_tready are both high; tready depends only on enable and FIFO fullness.

  logic                          full, empty, beat, push, pop;
  logic [63:0]                   head;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic [TS_W-1:0]               head_ts;
  logic                          ts_match, ts_late;

  state_t                state_q, state_d;
  logic [TS_W-1:0]       tb_q, tb_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   dac_q, dac_d;
  logic [31:0]           late_q, late_d;
  logic                  underrun_q, underrun_d;
  logic                  framing_q, framing_d;

  assign s_axis_tready = enable & ~full;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign push          = beat & (s_axis_tkeep == 8'hFF);
  assign head_ts       = get_ts(head);
  assign ts_match      = (head_ts == tb_q);
  assign ts_late       = (head_ts < tb_q);
  assign pop           = enable & (state_q == RUN) & ~empty & (ts_match | ts_late);

  sync_fifo_fwft #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (~enable),
    .push  (push),
    .wdata (s_axis_tdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_d    = state_q;
    tb_d       = tb_q;
    cnt_d      = cnt_q;
    dac_d      = dac_q;
    late_d     = late_q;
    underrun_d = underrun_q;
    framing_d  = framing_q;

    // Framing tracks every transferred beat, including ones dropped for a bad tkeep.
    if (beat) begin
      if (s_axis_tkeep != 8'hFF) framing_d = 1'b1;
      if (s_axis_tlast) begin
        if (cnt_q != packet_size - 32'd1) framing_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == packet_size - 32'd1) begin
        framing_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: state_d = ARM;
      ARM: begin
        if (level != '0) begin
          state_d = RUN;
          tb_d    = '0;
        end
      end
      RUN: begin
        tb_d = tb_q + TS_W'(TIME_STEP);
        if (empty) underrun_d = 1'b1;
        else if (ts_match) dac_d = get_sample(head);
        else if (ts_late && late_q != 32'hFFFF_FFFF) late_d = late_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      tb_d    = '0;
      cnt_d   = '0;
      dac_d   = IDLE_CODE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tb_q       <= '0;
      cnt_q      <= '0;
      dac_q      <= IDLE_CODE;
      late_q     <= '0;
      underrun_q <= 1'b0;
      framing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tb_q       <= tb_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      late_q     <= late_d;
      underrun_q <= underrun_d;
      framing_q  <= framing_d;
    end
  end

  assign dac_out     = dac_q;
  assign playing     = (state_q == RUN);
  assign fifo_level  = level;
  assign late_count  = late_q;
  assign underrun    = underrun_q;
  assign framing_err = framing_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_dac_player.sv
// Self-checking bench for axis_dac_player: directed scenarios plus randomized timestamp
// sequences scored against an event-level playback model.
module tb_axis_dac_player;
  import axis_dac_player_pkg::*;

  localparam int LOG_N = 16384;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] packet_size;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tkeep;
  logic [13:0] dac_out;
  logic        playing, underrun, framing_err;
  logic [9:0]  fifo_level;
  logic [31:0] late_count;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [13:0] dac_log  [0:LOG_N-1];
  logic        unr_log  [0:LOG_N-1];
  logic        play_log [0:LOG_N-1];

  logic [13:0] w_s  [0:31];
  logic [49:0] w_ts [0:31];

  always #5 clk = ~clk;

  axis_dac_player dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .packet_size   (packet_size),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .dac_out       (dac_out),
    .playing       (playing),
    .fifo_level    (fifo_level),
    .late_count    (late_count),
    .underrun      (underrun),
    .framing_err   (framing_err),
    .dbg_state_o   (dbg_state_o)
  );

  // Per-cycle observation log, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      dac_log[cyc]  = dac_out;
      unr_log[cyc]  = underrun;
      play_log[cyc] = playing;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tkeep = 8'hFF; s_axis_tdata = '0; packet_size = 32'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dac"},      dac_out, 14'h0000);
    chk({tag, "_playing"},  playing, 1'b0);
    chk({tag, "_level"},    fifo_level, 10'd0);
    chk({tag, "_late"},     late_count, 32'd0);
    chk({tag, "_underrun"}, underrun, 1'b0);
    chk({tag, "_framing"},  framing_err, 1'b0);
    chk({tag, "_tready"},   s_axis_tready, 1'b0);
    chk({tag, "_state"},    dbg_state_o, 2'd0);
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] keep, input logic last);
    int w;
    @(negedge clk);
    s_axis_tdata = d; s_axis_tkeep = keep; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    w = 0;
    while (s_axis_tready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("push_timeout_tready", s_axis_tready, 1'b1);
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = 8'hFF;
  endtask

  // Plays w_s/w_ts[0..n-1] as one packet from a fresh reset and scores the DAC trace.
  task automatic play(input int n, input string tag);
    int ev_k[$];
    logic [13:0] ev_s[$];
    longint k, kp, ts;
    int late, big_k, st, w, k0, e;
    logic [13:0] cur;

    // Model: timebase is 8*k at RUN cycle k; a head word is popped at the first cycle its
    // stamp is reached or passed, and a hit shows on the DAC one cycle after the pop.
    k = 0; late = 0;
    for (int i = 0; i < n; i++) begin
      ts = longint'(w_ts[i]);
      kp = k;
      if (ts > 8 * k) kp = (ts + 7) / 8;
      if (ts == 8 * kp) begin
        ev_k.push_back(int'(kp + 1));
        ev_s.push_back(w_s[i]);
      end else begin
        late++;
      end
      k = kp + 1;
    end
    big_k = int'(k);

    do_reset();
    chk_reset({tag, "_rst"});
    packet_size = n;
    st = cyc;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < n; i++) push({w_s[i], w_ts[i]}, 8'hFF, (i == n - 1));
    end_stream();
    w = 0;
    while (playing !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_run_entry"}, playing, 1'b1);
    repeat (big_k + 4) @(negedge clk);

    k0 = -1;
    for (int idx = st; idx < cyc - 1 && idx < LOG_N; idx++)
      if (k0 < 0 && play_log[idx] === 1'b1) k0 = idx;
    if (k0 < 0) k0 = st;

    cur = 14'h0000;
    e = 0;
    for (int kk = 0; kk <= big_k + 1; kk++) begin
      if (e < ev_k.size() && ev_k[e] == kk) begin
        cur = ev_s[e];
        e++;
      end
      chk($sformatf("%s_dac_k%0d", tag, kk), dac_log[k0 + kk], cur);
    end
    chk({tag, "_no_underrun_before_drain"}, unr_log[k0 + big_k], 1'b0);
    chk({tag, "_underrun_after_drain"}, unr_log[k0 + big_k + 1], 1'b1);
    chk({tag, "_late_count"}, late_count, late);
    chk({tag, "_framing"}, framing_err, 1'b0);

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk({tag, "_off_dac"}, dac_out, 14'h0000);
    chk({tag, "_off_level"}, fifo_level, 10'd0);
    chk({tag, "_off_playing"}, playing, 1'b0);
    chk({tag, "_off_underrun_kept"}, underrun, 1'b1);
    chk({tag, "_off_late_kept"}, late_count, late);
  endtask

  initial begin
    int n, extra, acc, c;
    longint prev;

    rst = 1'b1; enable = 1'b0; packet_size = 32'd1; s_axis_tdata = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = 8'hFF;

    // Two on-time samples.
    w_s[0] = 14'h0123; w_ts[0] = 50'd0;
    w_s[1] = 14'h0456; w_ts[1] = 50'd16;
    play(2, "t1");

    // Third stamp already in the past.
    w_s[0] = 14'h0AAA; w_ts[0] = 50'd0;
    w_s[1] = 14'h0BBB; w_ts[1] = 50'd8;
    w_s[2] = 14'h0CCC; w_ts[2] = 50'd4;
    play(3, "t2");

    // Randomized stamp sequences: hits, non-aligned stamps and stale stamps.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(8, 24);
      prev = 8 * longint'($urandom_range(30, 40));
      for (int i = 0; i < n; i++) begin
        w_s[i] = 14'($urandom);
        if (i > 0) begin
          c = $urandom_range(0, 3);
          case (c)
            0: prev = prev + 8 * longint'($urandom_range(1, 3));
            1: prev = prev + longint'($urandom_range(1, 7));
            2: prev = (prev > 40) ? prev - longint'($urandom_range(1, 40)) : 0;
            default: prev = prev + 8;
          endcase
        end
        w_ts[i] = 50'(prev);
      end
      play(n, $sformatf("rnd%0d", r));
    end

    // Backpressure at full.
    do_reset();
    packet_size = 32'd1024;
    @(negedge clk);
    enable = 1'b1;
    acc = 0;
    for (int i = 0; i < 512; i++) begin
      push({14'($urandom), 50'd1 << 40}, 8'hFF, 1'b0);
      acc++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    extra = 0;
    for (int i = 0; i < 88; i++) begin
      if (s_axis_tready === 1'b1) extra++;
      @(negedge clk);
    end
    end_stream();
    chk("t4_accepted", acc, 512);
    chk("t4_extra_accepted", extra, 0);
    chk("t4_level", fifo_level, 10'd512);
    chk("t4_tready", s_axis_tready, 1'b0);
    chk("t4_playing", playing, 1'b1);
    chk("t4_underrun", underrun, 1'b0);

    // Framing: good packet, short packet, good packet again.
    do_reset();
    packet_size = 32'd4;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push({14'h0001, 50'd1 << 40}, 8'hFF, (i == 3));
    end_stream();
    chk("t3_good_packet", framing_err, 1'b0);
    for (int i = 0; i < 3; i++) push({14'h0002, 50'd1 << 40}, 8'hFF, (i == 2));
    end_stream();
    chk("t3_short_packet", framing_err, 1'b1);
    for (int i = 0; i < 4; i++) push({14'h0003, 50'd1 << 40}, 8'hFF, (i == 3));
    end_stream();
    chk("t3_sticky", framing_err, 1'b1);
    chk("t3_level", fifo_level, 10'd11);

    // Packet overrunning its length without tlast.
    do_reset();
    packet_size = 32'd2;
    @(negedge clk);
    enable = 1'b1;
    push({14'h0004, 50'd1 << 40}, 8'hFF, 1'b0);
    end_stream();
    chk("t3_mid_packet", framing_err, 1'b0);
    push({14'h0005, 50'd1 << 40}, 8'hFF, 1'b0);
    end_stream();
    chk("t3_missing_tlast", framing_err, 1'b1);

    // Partial tkeep beat is dropped; reset clears stickies.
    do_reset();
    packet_size = 32'd1;
    @(negedge clk);
    enable = 1'b1;
    push({14'h0155, 50'd0}, 8'h0F, 1'b1);
    end_stream();
    chk("t6_not_buffered", fifo_level, 10'd0);
    chk("t6_framing", framing_err, 1'b1);
    chk("t6_not_playing", playing, 1'b0);
    do_reset();
    chk_reset("t6_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
